// File: rtl/imm_sign_ext_unit.sv
// rtl/imm_sign_ext_unit.sv - registered 12-to-32 bit immediate sign extension with self-check
//
// Purpose:
//   Sign-extends an IMM_W-bit immediate to XLEN bits in two independent ways
//   (bit replication, and left-align plus arithmetic right shift). It also
//   negates the replicated result. Both extensions are added to the negation,
//   and each sum must be zero. All results are registered with 1-cycle latency.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (priority over in_valid)
//   in_valid       imm is valid this cycle
//   imm            raw two's-complement immediate, IMM_W bits
//   out_valid      registered outputs hold a fresh result
//   ext_imm        sign extension by bit replication
//   ext_imm2       sign extension by left-align + arithmetic shift right
//   minus_ext_imm  two's-complement negation of ext_imm
//   zero / zero2   ext_imm + minus_ext_imm, ext_imm2 + minus_ext_imm (mod 2^XLEN)
//   match          ext_imm == ext_imm2
//   check_ok       both sums zero and both extensions equal
//   err_count      saturating count of registered results with check_ok = 0

module imm_sign_ext_unit #(
    parameter int IMM_W = 12,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    output logic [XLEN-1:0]  ext_imm,
    output logic [XLEN-1:0]  ext_imm2,
    output logic [XLEN-1:0]  minus_ext_imm,
    output logic [XLEN-1:0]  zero,
    output logic [XLEN-1:0]  zero2,
    output logic             match,
    output logic             check_ok,
    output logic [15:0]      err_count
);

    localparam int PAD_W = XLEN - IMM_W;

    // Combinational datapath
    logic [XLEN-1:0]        ext_a_c;
    logic signed [XLEN-1:0] aligned_c;
    logic [XLEN-1:0]        ext_b_c;
    logic [XLEN-1:0]        minus_c;
    logic [XLEN-1:0]        zero_c;
    logic [XLEN-1:0]        zero2_c;
    logic                   match_c;
    logic                   check_ok_c;

    always_comb begin
        ext_a_c    = {{PAD_W{imm[IMM_W-1]}}, imm};
        // Method B works directly from imm. The sign fill comes from the shifter,
        // so it shares nothing with method A.
        aligned_c  = {imm, {PAD_W{1'b0}}};
        ext_b_c    = XLEN'(aligned_c >>> PAD_W);
        minus_c    = (~ext_a_c) + XLEN'(1);
        zero_c     = ext_a_c + minus_c;
        zero2_c    = ext_b_c + minus_c;
        match_c    = (ext_a_c == ext_b_c);
        check_ok_c = (zero_c == '0) && (zero2_c == '0) && match_c;
    end

    // Registers
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] ext_imm_q, ext_imm_d;
    logic [XLEN-1:0] ext_imm2_q, ext_imm2_d;
    logic [XLEN-1:0] minus_q, minus_d;
    logic [XLEN-1:0] zero_q, zero_d;
    logic [XLEN-1:0] zero2_q, zero2_d;
    logic            match_q, match_d;
    logic            check_ok_q, check_ok_d;
    logic [15:0]     err_count_q, err_count_d;

    always_comb begin
        out_valid_d = in_valid;
        ext_imm_d   = ext_imm_q;
        ext_imm2_d  = ext_imm2_q;
        minus_d     = minus_q;
        zero_d      = zero_q;
        zero2_d     = zero2_q;
        match_d     = match_q;
        check_ok_d  = check_ok_q;
        err_count_d = err_count_q;
        if (in_valid) begin
            ext_imm_d  = ext_a_c;
            ext_imm2_d = ext_b_c;
            minus_d    = minus_c;
            zero_d     = zero_c;
            zero2_d    = zero2_c;
            match_d    = match_c;
            check_ok_d = check_ok_c;
            // Saturate instead of wrapping, so a long burst of faults stays visible.
            if (!check_ok_c && (err_count_q != 16'hFFFF)) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ext_imm_q   <= '0;
            ext_imm2_q  <= '0;
            minus_q     <= '0;
            zero_q      <= '0;
            zero2_q     <= '0;
            match_q     <= 1'b0;
            check_ok_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ext_imm_q   <= ext_imm_d;
            ext_imm2_q  <= ext_imm2_d;
            minus_q     <= minus_d;
            zero_q      <= zero_d;
            zero2_q     <= zero2_d;
            match_q     <= match_d;
            check_ok_q  <= check_ok_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign ext_imm       = ext_imm_q;
    assign ext_imm2      = ext_imm2_q;
    assign minus_ext_imm = minus_q;
    assign zero          = zero_q;
    assign zero2         = zero2_q;
    assign match         = match_q;
    assign check_ok      = check_ok_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_imm_sign_ext_unit.sv
// tb/tb_imm_sign_ext_unit.sv - directed-vector bench for imm_sign_ext_unit
module tb_imm_sign_ext_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] imm;
    logic        out_valid;
    logic [31:0] ext_imm, ext_imm2, minus_ext_imm, zero, zero2;
    logic        match, check_ok;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    imm_sign_ext_unit #(.IMM_W(12), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .imm          (imm),
        .out_valid    (out_valid),
        .ext_imm      (ext_imm),
        .ext_imm2     (ext_imm2),
        .minus_ext_imm(minus_ext_imm),
        .zero         (zero),
        .zero2        (zero2),
        .match        (match),
        .check_ok     (check_ok),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one input cycle, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic [11:0] i);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        imm      = i;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp_ext, input logic [31:0] exp_minus);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".ext_imm"},   ext_imm,        exp_ext);
        check({tag, ".ext_imm2"},  ext_imm2,       exp_ext);
        check({tag, ".minus"},     minus_ext_imm,  exp_minus);
        check({tag, ".zero"},      zero,           32'd0);
        check({tag, ".zero2"},     zero2,          32'd0);
        check({tag, ".match"},     32'(match),     32'd1);
        check({tag, ".check_ok"},  32'(check_ok),  32'd1);
        check({tag, ".err_count"}, 32'(err_count), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".ext_imm"},   ext_imm,        32'd0);
        check({tag, ".ext_imm2"},  ext_imm2,       32'd0);
        check({tag, ".minus"},     minus_ext_imm,  32'd0);
        check({tag, ".zero"},      zero,           32'd0);
        check({tag, ".zero2"},     zero2,          32'd0);
        check({tag, ".match"},     32'(match),     32'd0);
        check({tag, ".check_ok"},  32'(check_ok),  32'd0);
        check({tag, ".err_count"}, 32'(err_count), 32'd0);
    endtask

    typedef struct {
        string       tag;
        logic [11:0] imm;
        logic [31:0] ext;
        logic [31:0] minus;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; imm = '0;
        vecs.push_back('{"p5",     12'h005, 32'h00000005, 32'hFFFFFFFB});
        vecs.push_back('{"p12",    12'h00C, 32'h0000000C, 32'hFFFFFFF4});
        vecs.push_back('{"m5",     12'hFFB, 32'hFFFFFFFB, 32'h00000005});
        vecs.push_back('{"m12",    12'hFF4, 32'hFFFFFFF4, 32'h0000000C});
        vecs.push_back('{"p1337",  12'h539, 32'h00000539, 32'hFFFFFAC7});
        vecs.push_back('{"m2019",  12'h81D, 32'hFFFFF81D, 32'h000007E3});
        vecs.push_back('{"max",    12'h7FF, 32'h000007FF, 32'hFFFFF801});
        vecs.push_back('{"min",    12'h800, 32'hFFFFF800, 32'h00000800});
        vecs.push_back('{"zero",   12'h000, 32'h00000000, 32'h00000000});

        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b0, 12'h000);
        check_all_zero("reset_idle");

        // Back-to-back valid inputs; out_valid must stay high every cycle.
        foreach (vecs[k]) begin
            step(1'b0, 1'b1, vecs[k].imm);
            check_result(vecs[k].tag, vecs[k].ext, vecs[k].minus);
        end

        // Hold: outputs keep their values while out_valid drops.
        step(1'b0, 1'b1, 12'h005);
        check_result("hold_load", 32'h00000005, 32'hFFFFFFFB);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b0, 12'hABC);
            check("hold.out_valid", 32'(out_valid), 32'd0);
            check("hold.ext_imm",   ext_imm,        32'h00000005);
            check("hold.minus",     minus_ext_imm,  32'hFFFFFFFB);
            check("hold.check_ok",  32'(check_ok),  32'd1);
        end

        // Reset wins over in_valid.
        step(1'b1, 1'b1, 12'h123);
        check_all_zero("rst_over_valid");

        step(1'b0, 1'b0, 12'h000);
        check("post_rst.out_valid", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 12'h123);
        check_result("post_rst", 32'h00000123, 32'hFFFFFEDD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_sign_ext_unit.md
Name: imm_sign_ext_unit

Overview:
Registered immediate-extension unit. It sign-extends a 12-bit instruction immediate to 32 bits using two independent methods and computes the two's-complement negation of the result. It also self-checks both extensions by adding each to the negation, which must give zero. It sits in the decode stage as a 1-cycle pipelined immediate generator with a built-in consistency monitor.

Parameters:
IMM_W, 12, immediate input width (bits)
XLEN, 32, extended output width (bits); XLEN > IMM_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  imm is valid this cycle
imm  input  IMM_W  raw two's-complement immediate
out_valid  output  1  outputs below hold a fresh result
ext_imm  output  XLEN  sign extension, method A (bit replication)
ext_imm2  output  XLEN  sign extension, method B (left-align then arithmetic right shift)
minus_ext_imm  output  XLEN  two's-complement negation of method-A result
zero  output  XLEN  ext_imm + minus_ext_imm, mod 2^XLEN
zero2  output  XLEN  ext_imm2 + minus_ext_imm, mod 2^XLEN
match  output  1  ext_imm == ext_imm2
check_ok  output  1  zero == 0 and zero2 == 0 and match
err_count  output  16  count of valid results with check_ok = 0; saturates at 0xFFFF

Behaviour:
- Reset: when rst=1 at a rising edge, all outputs go to 0. This covers out_valid, the data outputs, match, check_ok and err_count. rst has priority over in_valid.
- Method A: ext = {(XLEN-IMM_W) copies of imm[IMM_W-1], imm}.
- Method B: place imm in bits [XLEN-1 : XLEN-IMM_W], fill the low bits with 0, then do a signed arithmetic right shift by XLEN-IMM_W. Method B must be an independent datapath; it must not reuse the method-A result.
- Negation: minus = (~ext_imm_comb) + 1, truncated to XLEN bits. minus(0) = 0.
- All arithmetic is unsigned modulo 2^XLEN. No overflow flag. The most-negative immediate is legal.
- Latency: 1 cycle. On an edge with in_valid=1 and rst=0, all data outputs, match and check_ok register the combinational results of imm, and out_valid becomes 1.
- On an edge with in_valid=0 and rst=0, out_valid becomes 0. Data outputs, match and check_ok hold their previous values.
- err_count increments by 1 on an edge where a result is registered and that result's check_ok is 0. It holds at 0xFFFF and does not wrap. In a correct implementation it stays at 0.
- There is no back-pressure. A new input may arrive every cycle.
- Reset asserted mid-stream discards the in-flight result. out_valid is 0 on the cycle after reset, and the first valid output appears 1 cycle after in_valid is seen with rst=0.
- Correct operation means match=1, check_ok=1, zero=0 and zero2=0 for every valid result.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 -> all outputs 0, err_count=0.
- imm=5, then imm=12 on back-to-back cycles -> ext_imm=ext_imm2=0x00000005 with minus=0xFFFFFFFB, then 0x0000000C with minus=0xFFFFFFF4. In both cases zero=zero2=0, check_ok=1, and out_valid=1 for 2 consecutive cycles.
- imm=-5 (0xFFB) -> ext=0xFFFFFFFB, minus=0x00000005. imm=-12 (0xFF4) -> ext=0xFFFFFFF4, minus=0x0000000C. Both extension outputs equal; match=1.
- imm=1337 (0x539) -> ext=0x00000539, minus=0xFFFFFAC7. imm=-2019 (0x81D) -> ext=0xFFFFF81D, minus=0x000007E3. zero=zero2=0 in both cases.
- Boundaries:
  - imm=0x7FF -> ext=0x000007FF, minus=0xFFFFF801.
  - imm=0x800 -> ext=0xFFFFF800, minus=0x00000800.
  - imm=0 -> ext=0, minus=0.
  - All give check_ok=1 and leave err_count at 0.
- Hold and reset: apply imm=5 with in_valid=1, then in_valid=0 for 3 cycles -> out_valid falls and ext_imm holds 0x00000005. Then assert rst together with in_valid=1, imm=0x123 -> all outputs are 0 on the next cycle.
